// File: rtl/bcd_scan_display.sv
// Multiplexed common-anode 7-segment scanner: snapshots the BCD digits once per frame,
// then alternates an all-off guard interval with a fixed dwell on each digit.
module bcd_scan_display #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD_CYC = 100
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start
);
    localparam int MAX_CYC = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    typedef enum logic {GUARD = 1'b0, DRIVE = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      pcnt_q, pcnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] snap_q, snap_d;
    logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_start_q;
    logic                  load_snap;
    logic [N_DIGITS-1:0]   zero_from;
    logic [3:0]            cur_digit;
    logic                  blank_now;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q       <= GUARD;
            pcnt_q        <= '0;
            idx_q         <= '0;
            snap_q        <= '0;
            snap_dp_q     <= '0;
            an_q          <= '1;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            snap_dp_q     <= snap_dp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= load_snap;
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q + 1'b1;
        idx_d   = idx_q;
        case (state_q)
            GUARD: begin
                if (pcnt_q == GUARD_LAST) begin
                    state_d = DRIVE;
                    pcnt_d  = '0;
                end
            end
            DRIVE: begin
                if (pcnt_q == SCAN_LAST) begin
                    state_d = GUARD;
                    pcnt_d  = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = GUARD;
                pcnt_d  = '0;
            end
        endcase
    end

    // The snapshot is taken in the very first guard cycle of digit 0, so every
    // digit of a frame is drawn from one coherent sample of the counters.
    assign load_snap = (state_q == GUARD) && (idx_q == '0) && (pcnt_q == '0);
    assign snap_d    = load_snap ? digits : snap_q;
    assign snap_dp_d = load_snap ? dp_in  : snap_dp_q;

    always_comb begin
        zero_from = '0;
        zero_from[N_DIGITS-1] = (snap_d[4*N_DIGITS-4 +: 4] == 4'd0);
        for (int i = N_DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = (snap_d[4*i +: 4] == 4'd0) && zero_from[i+1];
        end
    end

    // Outputs are computed from the next state so they change on the same edge.
    always_comb begin
        an_d      = '1;
        seg_d     = 7'h7F;
        dp_d      = 1'b1;
        cur_digit = snap_d[{idx_d, 2'b00} +: 4];
        blank_now = blank_lz && (idx_d != '0) && zero_from[idx_d];
        if (state_d == DRIVE) begin
            an_d[idx_d] = 1'b0;
            seg_d       = blank_now ? 7'h7F : decode(cur_digit);
            dp_d        = ~snap_dp_d[idx_d];
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: a frame-position model checks every cycle, with
// literal expectations at hand-picked edges.
module tb_bcd_scan_display;
    localparam int N = 4;
    localparam int S = 4;
    localparam int G = 2;
    localparam int FRAME = N * (G + S);

    logic          ck = 1'b0;
    logic          rst;
    logic [15:0]   digits;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    int since = 0;

    logic [6:0] dec [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    bcd_scan_display #(.N_DIGITS(N), .SCAN_DIV(S), .GUARD_CYC(G)) dut (
        .ck(ck), .rst(rst), .digits(digits), .dp_in(dp_in), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 ck = ~ck;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    always @(posedge ck or posedge rst) begin
        if (rst) since <= 0;
        else     since <= since + 1;
    end

    // Model: frame position after each edge, snapshot taken when the position wraps to 0.
    int          pos = 0;
    int          slot, sub;
    logic [15:0] m_snap = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  e_an, dval;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;

    always @(posedge ck) begin
        if (rst) begin
            pos = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            e_fs = (pos == 0);
            if (pos == 0) begin
                m_snap = digits;
                m_dp   = dp_in;
            end
            pos  = (pos + 1) % FRAME;
            slot = pos / (G + S);
            sub  = pos % (G + S);
            if (sub < G) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an = 4'hF & ~(4'b0001 << slot);
                dval = 4'((m_snap >> (4 * slot)) & 16'hF);
                if (blank_lz && slot != 0 && (m_snap >> (4 * slot)) == 16'h0)
                    e_seg = 7'h7F;
                else
                    e_seg = dec[dval];
                e_dp = ~m_dp[slot];
            end
        end
        #1;
        chk("model_an", 16'(an), 16'(e_an));
        chk("model_seg", 16'(seg), 16'(e_seg));
        chk("model_dp", 16'(dp), 16'(e_dp));
        chk("model_frame_start", 16'(frame_start), 16'(e_fs));
        chk("one_anode_low", 16'($countones(~an) <= 1), 16'd1);
    end

    task automatic goto(input int n);
        int budget = 2000;
        while (since != n && budget > 0) begin
            @(posedge ck);
            #2;
            budget--;
        end
        if (since != n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL goto_timeout: edge count %0d, wanted %0d", since, n);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge ck);
        #2;
        rst = 1'b0;
    endtask

    task automatic lit(input string name, input logic [3:0] ean, input logic [6:0] eseg);
        chk({name, "_an"}, 16'(an), 16'(ean));
        chk({name, "_seg"}, 16'(seg), 16'(eseg));
    endtask

    initial begin
        rst = 1'b1; digits = 16'h1234; dp_in = 4'b0100; blank_lz = 1'b0;
        repeat (3) @(posedge ck);
        #2;
        chk("reset_an", 16'(an), 16'hF);
        chk("reset_fs", 16'(frame_start), 16'h0);
        rst = 1'b0;

        // Decode and timing after release
        goto(1);  chk("fs_edge1", 16'(frame_start), 16'h1); chk("an_edge1", 16'(an), 16'hF);
        goto(2);  lit("d0_edge2", 4'hE, 7'h19); chk("dp_edge2", 16'(dp), 16'h1);
        goto(3);  chk("fs_edge3", 16'(frame_start), 16'h0);
        goto(5);  chk("an_edge5", 16'(an), 16'hE);
        goto(6);  lit("guard_edge6", 4'hF, 7'h7F);
        goto(7);  chk("an_edge7", 16'(an), 16'hF);
        goto(8);  lit("d1_edge8", 4'hD, 7'h30); chk("dp_edge8", 16'(dp), 16'h1);
        goto(14); lit("d2_edge14", 4'hB, 7'h24); chk("dp_edge14", 16'(dp), 16'h0);
        goto(20); lit("d3_edge20", 4'h7, 7'h79); chk("dp_edge20", 16'(dp), 16'h1);
        goto(25); chk("fs_edge25", 16'(frame_start), 16'h1);
        goto(26); lit("d0_edge26", 4'hE, 7'h19);

        // Asynchronous reset mid-drive
        goto(27);
        rst = 1'b1;
        #1;
        lit("async_rst", 4'hF, 7'h7F);
        chk("async_rst_dp", 16'(dp), 16'h1);
        chk("async_rst_fs", 16'(frame_start), 16'h0);
        @(posedge ck);
        #2;
        digits = 16'h0059; dp_in = 4'b0000;
        rst = 1'b0;

        // Tearing: change inputs while digit 1 is shown
        goto(8);  lit("tear_d1", 4'hD, 7'h12);
        goto(9);  digits = 16'h0100;
        goto(14); lit("tear_d2_old", 4'hB, 7'h40);
        goto(20); lit("tear_d3_old", 4'h7, 7'h40);
        goto(25); chk("tear_fs", 16'(frame_start), 16'h1);
        goto(26); lit("tear_d0_new", 4'hE, 7'h40);
        goto(38); lit("tear_d2_new", 4'hB, 7'h79);

        // Leading-zero blanking
        digits = 16'h0005; blank_lz = 1'b1;
        pulse_reset();
        goto(2);  lit("blank_d0", 4'hE, 7'h12);
        goto(8);  lit("blank_d1", 4'hD, 7'h7F);
        goto(14); lit("blank_d2", 4'hB, 7'h7F);
        goto(20); lit("blank_d3", 4'h7, 7'h7F);
        goto(21); digits = 16'h0000;
        goto(26); lit("zero_d0", 4'hE, 7'h40);
        goto(32); lit("zero_d1", 4'hD, 7'h7F);
        goto(33); digits = 16'h0A05;
        goto(50); lit("a05_d0", 4'hE, 7'h12);
        goto(56); lit("a05_d1", 4'hD, 7'h40);
        goto(62); lit("a05_d2", 4'hB, 7'h3F);
        goto(68); lit("a05_d3", 4'h7, 7'h7F);

        // Random digits, dp requests and blanking over ten frames
        for (int c = 0; c < 10 * FRAME; c++) begin
            @(posedge ck);
            #2;
            if ($urandom_range(0, 5) == 0) begin
                digits   = 16'($urandom);
                dp_in    = 4'($urandom);
                blank_lz = 1'($urandom);
            end
        end

        @(posedge ck);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Multiplexed 7-segment driver that consumes the packed BCD digit outputs of the clock counter chain (seconds/minutes counters) and scans them onto a common-anode display. Each frame, it snapshots all digits so that a counter update mid-frame cannot tear the display. Each digit is driven for a fixed dwell. A guard interval with all anodes off sits between digits to suppress ghosting. The block sits between the counters and the board pins.

## Interface
- N_DIGITS, 4, number of digits scanned (1..8); digit 0 is least significant, rightmost.
- SCAN_DIV, 50000, clock cycles each digit is driven (≥1).
- GUARD_CYC, 100, clock cycles all anodes are off before each digit (≥1).

- ck  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- digits  input  4*N_DIGITS  packed BCD; digit i at [4i+3:4i].
- dp_in  input  N_DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  input  1  1 = leading-zero blanking enabled.
- an  output  N_DIGITS  anode enables, active-low.
- seg  output  7  segments {g,f,e,d,c,b,a} = seg[6:0], active-low.
- dp  output  1  decimal point, active-low.
- frame_start  output  1  one-cycle pulse marking the cycle after a snapshot load.

## Operation
- Registers:
  - state ∈ {GUARD, DRIVE}.
  - Phase counter pcnt, width clog2(max(SCAN_DIV,GUARD_CYC)).
  - Digit index idx, range 0..N_DIGITS-1.
  - Snapshot snap[4*N_DIGITS-1:0] and snap_dp[N_DIGITS-1:0].
- Reset (asynchronous, immediate):
  - state=GUARD, pcnt=0, idx=0, snap=0, snap_dp=0.
  - an=all 1, seg=7'h7F, dp=1, frame_start=0.
- GUARD:
  - If pcnt==GUARD_CYC-1, go to DRIVE with pcnt=0; else pcnt+1.
  - Outputs: an all 1, seg=7'h7F, dp=1.
- DRIVE:
  - If pcnt==SCAN_DIV-1, go to GUARD with pcnt=0 and idx = (idx==N_DIGITS-1) ? 0 : idx+1.
  - Otherwise pcnt+1.
  - Outputs: an[idx]=0 and all other an bits 1; seg=decode(digit idx of snap); dp=~snap_dp[idx].
- Snapshot:
  - On the edge where state==GUARD, idx==0 and pcnt==0, load snap←digits and snap_dp←dp_in.
  - frame_start is 1 for the cycle following that edge.
  - Input changes at any other time have no visible effect until the next frame.
- Decode (active-low, hex of seg[6:0]):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
  - Codes 10–15 → 3F (dash, g only).
- Leading-zero blanking (blank_lz=1):
  - Digit i≥1 is blanked when snap digits i..N_DIGITS-1 are all 0.
  - Blanked means seg=7'h7F. The anode is still driven and dp still honours snap_dp.
  - Digit 0 is never blanked.
  - blank_lz is sampled combinationally and is not snapshotted.
- Outputs are registered, updated on the same edge as state, and glitch-free. There is never more than one anode low.

## Timing
- Frame length = N_DIGITS*(GUARD_CYC+SCAN_DIV) cycles.
- Snapshots occur exactly once per frame, on the first edge after reset release and every frame length thereafter.
- First digit-0 DRIVE begins GUARD_CYC edges after reset release, counting the snapshot edge.
- Each DRIVE spans exactly SCAN_DIV cycles; each GUARD spans exactly GUARD_CYC cycles. No cycle belongs to both.
- GUARD_CYC=1 or SCAN_DIV=1: a single-cycle phase, with no skipped or doubled phases.
- Index wrap N_DIGITS-1→0 passes through GUARD like any other transition; the snapshot lands in that GUARD's first cycle.
- Reset mid-DRIVE: anodes off immediately. On release the block restarts from the snapshot edge, with no partial dwell.

## Test plan
All scenarios use N_DIGITS=4, SCAN_DIV=4, GUARD_CYC=2.
- Reset:
  - Stimulus: assert rst mid-DRIVE.
  - Required: same cycle an=4'hF, seg=7F, dp=1.
  - After release: frame_start=1 after edge 1; an=4'hE from edge 2 through edge 5; an=4'hF after edges 6–7; an=4'hD from edge 8.
- Decode:
  - Stimulus: digits=16'h1234, dp_in=4'b0100, blank_lz=0.
  - Required (digit 0..3): seg=19/30/24/79; dp=0 only while an=4'hB.
  - Frame repeats every 24 cycles.
- Tearing:
  - Stimulus: load 16'h0059; change digits to 16'h0100 while digit 1 is driven.
  - Required: digit 2 still shows 40 this frame; new value appears only after the next frame_start.
- Blanking:
  - Stimulus: digits=16'h0005, blank_lz=1.
  - Required: digits 3..1 seg=7F with anode low; digit 0 seg=12.
  - digits=16'h0000 → digit 0 shows 40.
  - digits=16'h0A05 → digit 2 shows 3F, digit 3 blank.
- Anode invariant:
  - Stimulus: random digits and dp_in over 10 frames.
  - Required: popcount(~an)≤1 every cycle; DRIVE/GUARD lengths exactly 4/2.
